// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_prefetch_queue : sequential instruction fetch with a DEPTH-entry prefetch queue
// Rev 1.0
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
  parameter int                INC      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          jpc,
  input  logic                       if_pc_jump,
  input  logic                       if_bubble,
  output logic                       im_req,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic                       im_ack,
  input  logic [DATA_W-1:0]          im_data,
  output logic                       ins_valid,
  output logic [DATA_W-1:0]          ins,
  output logic [ADDR_W-1:0]          ins_pc,
  output logic [ADDR_W-1:0]          npc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   fpc_q;
  logic [ADDR_W-1:0]   im_addr_q;
  logic                im_req_q;

  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];

  logic                w_pop;
  logic                w_push;
  logic [CW-1:0]       w_cnt_after_pop;
  logic                w_room_idle;
  logic                w_room_next;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign ins_valid       = (count_q != '0);
  assign w_pop           = ins_valid & ~if_bubble & ~if_pc_jump;
  assign w_push          = (state_q == S_WAIT) & im_ack & ~if_pc_jump;
  assign w_cnt_after_pop = count_q - CW'(w_pop);
  assign w_room_idle     = (w_cnt_after_pop < CW'(DEPTH));
  assign w_room_next     = ((w_cnt_after_pop + CW'(1)) < CW'(DEPTH));
  assign w_addr_inc      = im_addr_q + ADDR_W'(INC);

  // Issue is gated on the space left after this cycle's pop, so a push never
  // meets a full queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fpc_q     <= RESET_PC;
      im_addr_q <= RESET_PC;
      im_req_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_pc_jump) begin
            fpc_q <= jpc;
          end else if (w_room_idle) begin
            im_addr_q <= fpc_q;
            im_req_q  <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (im_ack && if_pc_jump) begin
            fpc_q    <= jpc;
            im_req_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (im_ack) begin
            fpc_q <= w_addr_inc;
            if (w_room_next) begin
              im_addr_q <= w_addr_inc;
            end else begin
              im_req_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end else if (if_pc_jump) begin
            fpc_q   <= jpc;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The outstanding request must complete; its data is discarded.
          if (if_pc_jump) begin
            fpc_q <= jpc;
          end
          if (im_ack) begin
            im_req_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          im_req_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(w_pop);
    wr_ptr_d = wr_ptr_q + PW'(w_push);
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    if (if_pc_jump) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      pc_mem[wr_ptr_q]   <= im_addr_q;
      data_mem[wr_ptr_q] <= im_data;
    end
  end

  assign im_req  = im_req_q;
  assign im_addr = im_addr_q;
  assign q_count = count_q;
  assign ins     = ins_valid ? data_mem[rd_ptr_q] : '0;
  assign ins_pc  = ins_valid ? pc_mem[rd_ptr_q] : '0;
  assign npc     = ins_valid ? (pc_mem[rd_ptr_q] + ADDR_W'(INC)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue : randomized scoreboard bench for if_prefetch_queue
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] jpc = '0;
  logic          if_pc_jump = 1'b0;
  logic          if_bubble = 1'b0;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack = 1'b0;
  logic [DW-1:0] im_data = '0;
  logic          ins_valid;
  logic [DW-1:0] ins;
  logic [AW-1:0] ins_pc;
  logic [AW-1:0] npc;
  logic [2:0]    q_count;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC), .INC(4)
  ) dut (
    .clk(clk), .rst(rst), .jpc(jpc), .if_pc_jump(if_pc_jump),
    .if_bubble(if_bubble), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_data(im_data), .ins_valid(ins_valid),
    .ins(ins), .ins_pc(ins_pc), .npc(npc), .q_count(q_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the expected instruction stream as {pc, data} pairs,
  // the next sequential fetch address, and whether the outstanding request
  // has been made stale by a jump.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc = RPC;
  bit          stale = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Monitor: retires the head whenever decode consumes it.
  logic        p_req  = 1'b0;
  logic        p_ack  = 1'b0;
  logic        p_rst  = 1'b1;
  logic [31:0] p_addr = '0;
  logic [63:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      chk("q_count_bound", 32'(q_count <= 3'(DEPTH)), 32'd1);
      if (!ins_valid) begin
        chk("empty_ins", ins, 32'd0);
        chk("empty_ins_pc", ins_pc, 32'd0);
        chk("empty_npc", npc, 32'd0);
      end else if (!if_bubble && !if_pc_jump) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h expected no entry", ins_pc);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", ins_pc, e[63:32]);
          chk("head_ins", ins, e[31:0]);
          chk("head_npc", npc, e[63:32] + 32'd4);
        end
      end
      if (p_req && !p_ack && !p_rst) begin
        chk("req_held", 32'(im_req), 32'd1);
        chk("addr_stable", im_addr, p_addr);
      end
    end
    p_req  <= im_req;
    p_ack  <= im_ack;
    p_rst  <= rst;
    p_addr <= im_addr;
  end

  // One cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input logic bub, input logic jmp, input logic [31:0] ja,
                     input logic ak);
    if_bubble  = bub;
    if_pc_jump = jmp;
    jpc        = ja;
    im_ack     = ak & im_req;
    im_data    = $urandom;
    if (im_ack) begin
      if (!stale && !jmp) begin
        chk("fetch_addr", im_addr, m_fpc);
        exp_q.push_back({m_fpc, im_data});
        m_fpc = m_fpc + 32'd4;
      end
      stale = 1'b0;
    end else if (im_req && jmp) begin
      stale = 1'b1;
    end
    if (jmp) begin
      exp_q.delete();
      m_fpc = ja;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    if_bubble  = 1'b0;
    if_pc_jump = 1'b0;
    im_ack     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_fpc = RPC;
    stale = 1'b0;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_im_addr", im_addr, RPC);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_npc", npc, 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
  endtask

  int unsigned ack_pct [4] = '{100, 60, 30, 90};
  int unsigned bub_pct [4] = '{0, 30, 70, 50};
  int unsigned jmp_pct [4] = '{0, 5, 3, 10};

  initial begin
    logic [31:0] ja;
    do_reset(3);

    // First request one cycle after reset release, then streaming fetch.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("first_req", 32'(im_req), 32'd1);
    chk("first_addr", im_addr, RPC);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1);
      if (i >= 1) chk("no_gap", 32'(ins_valid), 32'd1);
    end

    // Decode stall fills the queue and halts fetch.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("full_count", 32'(q_count), 32'(DEPTH));
    chk("full_no_req", 32'(im_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'd0, 1'b1);
      chk("hold_pc", ins_pc, exp_q[0][63:32]);
      chk("hold_ins", ins, exp_q[0][31:0]);
    end

    // Jump with full queue under stall: flush wins.
    cyc(1'b1, 1'b1, 32'h8000_0400, 1'b0);
    chk("flush_count", 32'(q_count), 32'd0);
    chk("flush_valid", 32'(ins_valid), 32'd0);

    // Jump while a request is outstanding, ack arrives three cycles late.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("redir_req", 32'(im_req), 32'd1);
    chk("redir_addr", im_addr, 32'h8000_0400);
    cyc(1'b0, 1'b1, 32'h8000_1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0);
      chk("drain_req", 32'(im_req), 32'd1);
      chk("drain_valid", 32'(ins_valid), 32'd0);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drop_valid", 32'(ins_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("drain_next_addr", im_addr, 32'h8000_1000);

    // Jump coincident with an ack.
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    chk("pre_jack_req", 32'(im_req), 32'd1);
    cyc(1'b0, 1'b1, 32'h8000_1000, 1'b1);
    chk("jack_valid", 32'(ins_valid), 32'd0);
    chk("jack_count", 32'(q_count), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("jack_next_addr", im_addr, 32'h8000_1000);

    // Randomized traffic phases.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        ja = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) ja = 32'hFFFF_FFF8;
        cyc(1'($urandom_range(0, 99) < bub_pct[p]),
            1'($urandom_range(0, 99) < jmp_pct[p]),
            ja,
            1'($urandom_range(0, 99) < ack_pct[p]));
      end
    end

    // Reset during an outstanding request, followed by a stray ack.
    for (int i = 0; i < 10 && !im_req; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pre_rst_req", 32'(im_req), 32'd1);
    do_reset(1);
    im_ack  = 1'b1;
    im_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    im_ack = 1'b0;
    chk("stray_count", 32'(q_count), 32'd0);
    chk("stray_valid", 32'(ins_valid), 32'd0);
    chk("stray_req", 32'(im_req), 32'd1);
    chk("stray_addr", im_addr, RPC);
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4),
          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 99) < 70));
    end

    // Quiesce: everything accepted must still be queued.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
    chk("final_count", 32'(q_count), 32'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
